data_ram_arbiter: RTL

Two-port arbiter that shares the single-ported data RAM between the CPU memory stage (master 0) and a secondary requester such as a DMA or debug port (master 1). It sits directly in front of the data RAM. It accepts held request/acknowledge transactions from both masters, picks one by round-robin, captures its command into registers and drives exactly one RAM access per granted cycle. Read data is returned in the acknowledge cycle, and a stall signal is provided for the pipeline.

---
 rtl/data_ram_arbiter.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/data_ram_arbiter.sv
// Round-robin arbiter sharing one single-ported data RAM between the CPU
// memory stage (master 0) and a secondary requester (master 1).
module data_ram_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  // master 0
  input  logic                  m0_req,
  input  logic                  m0_we,
  input  logic [ADDR_W-1:0]     m0_addr,
  input  logic [DATA_W/8-1:0]   m0_sel,
  input  logic [DATA_W-1:0]     m0_wdata,
  output logic [DATA_W-1:0]     m0_rdata,
  output logic                  m0_ack,
  output logic                  m0_stall,
  // master 1
  input  logic                  m1_req,
  input  logic                  m1_we,
  input  logic [ADDR_W-1:0]     m1_addr,
  input  logic [DATA_W/8-1:0]   m1_sel,
  input  logic [DATA_W-1:0]     m1_wdata,
  output logic [DATA_W-1:0]     m1_rdata,
  output logic                  m1_ack,
  // RAM port
  output logic                  ram_ce,
  output logic                  ram_we,
  output logic [ADDR_W-1:0]     ram_addr,
  output logic [DATA_W/8-1:0]   ram_sel,
  output logic [DATA_W-1:0]     ram_wdata,
  input  logic [DATA_W-1:0]     ram_rdata
);

  localparam int unsigned SEL_W = DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                last_q, last_d;
  logic                cmd_we_q, cmd_we_d;
  logic [ADDR_W-1:0]   cmd_addr_q, cmd_addr_d;
  logic [SEL_W-1:0]    cmd_sel_q, cmd_sel_d;
  logic [DATA_W-1:0]   cmd_wdata_q, cmd_wdata_d;

  logic                ld0_c, ld1_c;
  logic                gnt0_c, gnt1_c, gnt_any_c;

  // State, round-robin history and captured command registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      last_q      <= 1'b1;
      cmd_we_q    <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_sel_q   <= '0;
      cmd_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      cmd_we_q    <= cmd_we_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_sel_q   <= cmd_sel_d;
      cmd_wdata_q <= cmd_wdata_d;
    end
  end

  // Next grant decision; the granted master's command is captured on entry
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    cmd_we_d    = cmd_we_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_sel_d   = cmd_sel_q;
    cmd_wdata_d = cmd_wdata_q;
    ld0_c       = 1'b0;
    ld1_c       = 1'b0;

    case (state_q)
      IDLE: begin
        // on a tie, the master not served last wins
        if (m0_req && (!m1_req || last_q)) begin
          ld0_c = 1'b1;
        end else if (m1_req) begin
          ld1_c = 1'b1;
        end
      end
      GNT0: begin
        // the current m0 request is consumed, so m0_req is not looked at
        last_d = 1'b0;
        if (m1_req) begin
          ld1_c = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      GNT1: begin
        last_d = 1'b1;
        if (m0_req) begin
          ld0_c = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (ld0_c) begin
      state_d     = GNT0;
      cmd_we_d    = m0_we;
      cmd_addr_d  = m0_addr;
      cmd_sel_d   = m0_sel;
      cmd_wdata_d = m0_wdata;
    end else if (ld1_c) begin
      state_d     = GNT1;
      cmd_we_d    = m1_we;
      cmd_addr_d  = m1_addr;
      cmd_sel_d   = m1_sel;
      cmd_wdata_d = m1_wdata;
    end
  end

  // RAM access and acknowledge for the granted master; suppressed under reset
  always_comb begin
    gnt0_c    = (state_q == GNT0) && !rst;
    gnt1_c    = (state_q == GNT1) && !rst;
    gnt_any_c = gnt0_c || gnt1_c;

    ram_ce    = gnt_any_c;
    ram_we    = gnt_any_c && cmd_we_q;
    ram_addr  = gnt_any_c ? cmd_addr_q  : '0;
    ram_sel   = gnt_any_c ? cmd_sel_q   : '0;
    ram_wdata = gnt_any_c ? cmd_wdata_q : '0;

    m0_ack    = gnt0_c;
    m1_ack    = gnt1_c;
    m0_rdata  = (gnt0_c && !cmd_we_q) ? ram_rdata : '0;
    m1_rdata  = (gnt1_c && !cmd_we_q) ? ram_rdata : '0;
    m0_stall  = m0_req && !gnt0_c;
  end

endmodule
